// File: rtl/ex_div_unit_pkg.sv
// Shared encodings for the EX-stage multi-cycle divider.
package ex_div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/ex_div_unit.sv
// Restoring radix-2 signed/unsigned divider; one quotient bit per clock,
// result {remainder, quotient} held for EX until start_i drops.
//
// state       | meaning
// DIV_FREE    | idle, waiting for start_i
// DIV_BY_ZERO | divisor was zero, result forced to 0
// DIV_ON      | iterating, one quotient bit per edge
// DIV_END     | result valid, held until start_i falls
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  div_state_e state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  // {partial_rem, quot}; the partial remainder's top bit is always zero
  // after a step, so only the shifted compare value carries the extra bit.
  logic [2*DATA_W-1:0] work, work_nxt;
  logic [DATA_W-1:0]   divisor, divisor_nxt;
  logic                is_signed, is_signed_nxt;
  logic                neg1, neg1_nxt;
  logic                neg2, neg2_nxt;
  logic [2*DATA_W-1:0] result_nxt;
  logic                ready_nxt;

  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W:0]     rem_shift, rem_diff;
  logic [2*DATA_W-1:0] step_work;
  logic [DATA_W-1:0]   quot_fix, rem_fix;

  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  always_comb begin
    rem_shift = {work[2*DATA_W-1:DATA_W], work[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    step_work = {rem_shift[DATA_W-1:0], work[DATA_W-2:0], 1'b0};
    if (rem_shift >= {1'b0, divisor}) begin
      step_work = {rem_diff[DATA_W-1:0], work[DATA_W-2:0], 1'b1};
    end
  end

  assign quot_fix = (is_signed && (neg1 ^ neg2)) ? -work[DATA_W-1:0] : work[DATA_W-1:0];
  assign rem_fix  = (is_signed && neg1) ? -work[2*DATA_W-1:DATA_W] : work[2*DATA_W-1:DATA_W];

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    work_nxt      = work;
    divisor_nxt   = divisor;
    is_signed_nxt = is_signed;
    neg1_nxt      = neg1;
    neg2_nxt      = neg2;
    result_nxt    = result_o;
    ready_nxt     = ready_o;
    case (state)
      DIV_FREE: begin
        result_nxt = '0;
        ready_nxt  = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nxt = DIV_BY_ZERO;
          end else begin
            state_nxt     = DIV_ON;
            cnt_nxt       = '0;
            work_nxt      = {{DATA_W{1'b0}}, op1_abs};
            divisor_nxt   = op2_abs;
            is_signed_nxt = signed_div_i;
            neg1_nxt      = opdata1_i[DATA_W-1];
            neg2_nxt      = opdata2_i[DATA_W-1];
          end
        end
      end
      DIV_BY_ZERO: begin
        state_nxt  = DIV_END;
        result_nxt = '0;
        ready_nxt  = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_nxt = DIV_FREE;
        end else if (cnt != LAST_CNT) begin
          work_nxt = step_work;
          cnt_nxt  = cnt + CNT_W'(1);
        end else begin
          state_nxt  = DIV_END;
          result_nxt = {rem_fix, quot_fix};
          ready_nxt  = DIV_RESULT_READY;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_nxt  = DIV_FREE;
          result_nxt = '0;
          ready_nxt  = DIV_RESULT_NOT_READY;
        end
      end
      default: state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DIV_FREE;
      cnt       <= '0;
      work      <= '0;
      divisor   <= '0;
      is_signed <= 1'b0;
      neg1      <= 1'b0;
      neg2      <= 1'b0;
      result_o  <= '0;
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      work      <= work_nxt;
      divisor   <= divisor_nxt;
      is_signed <= is_signed_nxt;
      neg1      <= neg1_nxt;
      neg2      <= neg2_nxt;
      result_o  <= result_nxt;
      ready_o   <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: stimulus pushes expected results and
// completion cycles; a negedge monitor pops and checks on ready_o.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;

  ex_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Truncating division, remainder takes the dividend's sign; 64-bit math
  // keeps the -2^31 / -1 case well defined (wraps to 0x80000000).
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor
  logic        prev_ready = 1'b0;
  logic [63:0] held;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst) begin
      if (ready_o && !prev_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_ready: ready_o rose at cycle %0d with nothing expected, result %h", cyc, result_o);
        end else begin
          e = sb.pop_front();
          tests++;
          if (result_o !== e.res) begin
            fails++;
            $display("FAIL result: got %h expected %h", result_o, e.res);
          end
          tests++;
          if (cyc != e.due) begin
            fails++;
            $display("FAIL latency: ready at cycle %0d expected cycle %0d", cyc, e.due);
          end
        end
        held = result_o;
      end else if (ready_o && prev_ready) begin
        tests++;
        if (result_o !== held) begin
          fails++;
          $display("FAIL hold: got %h expected %h", result_o, held);
        end
      end else if (!ready_o && prev_ready) begin
        tests++;
        if (result_o !== 64'd0) begin
          fails++;
          $display("FAIL clear: result %h expected 0 after ready fell", result_o);
        end
      end
    end
    prev_ready = ready_o;
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      tests++; fails++;
      $display("FAIL timeout: ready_o not seen within 40 cycles");
    end
  endtask

  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t x;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    x.res = model(sgn, a, b);
    x.due = cyc + ((b == 32'd0) ? 2 : 34);
    sb.push_back(x);
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    wait_ready();
    repeat (hold) @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    exp_t x;
    int   n;
    bit   sgn;
    logic [31:0] a, b;

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    tests++;
    if (result_o !== 64'd0) begin fails++; $display("FAIL reset_result: got %h expected 0", result_o); end
    rst = 1'b0;
    @(negedge clk);

    do_div(1'b0, 32'd100, 32'd7, 2);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1);
    do_div(1'b1, 32'd5, 32'd0, 3);
    do_div(1'b0, 32'hFFFF_1234, 32'd0, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1);

    // Annul at cnt=10: nothing may be produced.
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (11) @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    repeat (40) @(negedge clk);
    do_div(1'b0, 32'd9, 32'd3, 0);

    // Reset at cnt=20 with start held through it.
    start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    signed_div_i = 1'b1; opdata1_i = 32'hFFFF_FF9C; opdata2_i = 32'd7;
    @(negedge clk);
    tests++;
    if (ready_o !== 1'b0) begin fails++; $display("FAIL midreset_ready: got %b expected 0", ready_o); end
    tests++;
    if (result_o !== 64'd0) begin fails++; $display("FAIL midreset_result: got %h expected 0", result_o); end
    rst = 1'b0;
    x.res = model(1'b1, 32'hFFFF_FF9C, 32'd7);
    x.due = cyc + 34;
    sb.push_back(x);
    @(negedge clk);
    opdata1_i = $urandom; opdata2_i = $urandom;
    wait_ready();
    start_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: b = $urandom;
        4: b = ($urandom | 32'd1) >> $urandom_range(0, 31);
        default: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      endcase
      do_div(sgn, a, b, int'($urandom_range(0, 3)));
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
Multi-cycle 32-bit signed/unsigned divider sequenced from the EX stage.
- EX raises start_i with operands and holds it until ready_o.
- While the divider is busy, EX drives its stall request, freezing the pipeline.
- Restoring radix-2 algorithm, one quotient bit per cycle; result {remainder, quotient} returned to EX for HI/LO write.

Parameters:
DATA_W, 32, operand width; counter and shift register sized from it.
CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high (`RstEnable)
start_i  input  1  request a divide; held high by EX until ready_o seen
annul_i  input  1  cancel the in-flight divide (branch/flush)
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
opdata1_i  input  DATA_W  dividend
opdata2_i  input  DATA_W  divisor
result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}
ready_o  output  1  result_o valid

Behaviour:
- Reset (rst high at an edge, any state): state=DIV_FREE, cnt=0, result_o=0, ready_o=0. Reset mid-divide discards all work.
- States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
- DIV_FREE
  - start_i=1, annul_i=0, divisor==0 -> DIV_BY_ZERO.
  - start_i=1, annul_i=0, divisor!=0 -> DIV_ON, cnt=0. Latch |dividend| and |divisor| when signed_div_i=1 (two's-complement negate if bit 31 set), else raw values. Latch signed_div_i and both operand sign bits.
  - Otherwise stay in DIV_FREE; ready_o=0, result_o=0.
- DIV_BY_ZERO: next edge -> DIV_END with result_o=0, ready_o=1.
- DIV_ON: if annul_i=1 -> DIV_FREE, nothing produced. Otherwise, while cnt<32, one step per edge:
  - 65-bit working register {partial_rem[32:0], quot[31:0]}, shifted left by 1.
  - If shifted partial_rem >= divisor: subtract the divisor and set quotient LSB to 1, else set it to 0.
  - cnt++.
- DIV_ON, cnt==32 edge -> DIV_END, ready_o=1, result_o loaded with sign fix-up:
  - quotient negated if signed and operand signs differ;
  - remainder negated if signed and dividend negative.
- DIV_END: result_o and ready_o hold while start_i=1. When start_i=0 -> DIV_FREE, ready_o=0, result_o=0.
- annul_i is ignored in DIV_BY_ZERO and DIV_END; EX deasserts start_i on flush.
- Latency, with E0 the edge that samples start_i:
  - normal divide: ready_o high after E33 (E1..E32 iterate, E33 fix-up);
  - divide-by-zero: ready_o high after E1.
- Overflow 0x80000000 / 0xFFFFFFFF (signed): quotient wraps to 0x80000000, remainder 0; no trap.
- Operand changes on the inputs after E0 have no effect.
- Back-to-back divides: start_i must fall for at least one cycle (DIV_END -> DIV_FREE) before a new start is accepted.

Decomposition:
- defines.v gains:
  - state encodings DivFree/DivByZero/DivOn/DivEnd (2 bits);
  - DivStart/DivStop;
  - DivResultReady/DivResultNotReady;
  - DoubleRegBus [63:0].
- The EX aluop/alusel codes for DIV/DIVU are also added there.
- Single module; no sub-module needed. The 33-bit compare/subtract step stays as an inline combinational block.

Test Plan:
- Unsigned 100 / 7, start held -> after E33: ready_o=1, result_o={32'd2, 32'd14}; after start_i drops, ready_o=0 and result_o=0 next edge.
- Signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0, any dividend -> ready_o=1 after E1, result_o=0; stays until start_i=0.
- Signed 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}. Unsigned 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- annul_i pulsed at cnt=10 -> DIV_FREE next edge; ready_o never rises. A new 9 / 3 start then yields {0, 3} after 33 more edges.
- rst high at cnt=20 -> outputs zero next edge, FSM in DIV_FREE. start_i held through the reset starts a fresh divide on the first edge with rst low.
